// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hold/flush sequencer for the 5-stage core.
//
// Produces per-stage hold, bubble and flush controls plus the PC redirect. Four stall/redirect
// sources are arbitrated: EX jumps (highest), mul/div issue, bus wait and load-use hazards.
// A jump seen while the bus is stalled is parked in pend_addr and replayed once the bus frees.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   jump_en_i, jump_addr_i    EX-stage taken jump and target
//   ex_load_i, ex_rd_i        EX instruction is a load / its destination
//   id_rs{1,2}_i, _en_i       ID source registers and read enables
//   md_start_i, md_done_i     mul/div issue pulse and result valid
//   bus_wait_i                memory bus not ready
//   hold_pc_o, hold_if_id_o, hold_id_ex_o   stage holds
//   bubble_id_ex_o, bubble_ex_mem_o         insert NOP into ID/EX, EX/MEM
//   flush_o                   flush IF/ID and ID/EX
//   jump_en_o, jump_addr_o    PC redirect (address is 0 when not redirecting)
//   md_timeout_o              one-cycle pulse when a mul/div is force-released
//   stall_cnt_o               saturating count of cycles with hold_pc_o set
module pipe_ctrl #(
   parameter int unsigned AW         = 32,
   parameter int unsigned MD_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          jump_en_i,
   input  logic [AW-1:0] jump_addr_i,
   input  logic          ex_load_i,
   input  logic [4:0]    ex_rd_i,
   input  logic [4:0]    id_rs1_i,
   input  logic [4:0]    id_rs2_i,
   input  logic          id_rs1_en_i,
   input  logic          id_rs2_en_i,
   input  logic          md_start_i,
   input  logic          md_done_i,
   input  logic          bus_wait_i,
   output logic          hold_pc_o,
   output logic          hold_if_id_o,
   output logic          hold_id_ex_o,
   output logic          bubble_id_ex_o,
   output logic          bubble_ex_mem_o,
   output logic          flush_o,
   output logic          jump_en_o,
   output logic [AW-1:0] jump_addr_o,
   output logic          md_timeout_o,
   output logic [15:0]   stall_cnt_o
);

   localparam int unsigned CW = $clog2(MD_TIMEOUT);
   localparam logic [CW-1:0] MdLast = CW'(MD_TIMEOUT - 1);

   typedef enum logic [1:0] {StRun, StMdWait, StJmpPend} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   md_cnt_q, md_cnt_d;
   logic [AW-1:0]   pend_addr_q, pend_addr_d;
   logic [15:0]     stall_cnt_q, stall_cnt_d;
   logic            load_use;

   // x0 is never a real dependency, so a load to x0 cannot cause a hazard.
   assign load_use = ex_load_i && (ex_rd_i != 5'd0) &&
                     ((id_rs1_en_i && (id_rs1_i == ex_rd_i)) ||
                      (id_rs2_en_i && (id_rs2_i == ex_rd_i)));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StRun;
         md_cnt_q    <= '0;
         pend_addr_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt_q    <= md_cnt_d;
         pend_addr_q <= pend_addr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      md_cnt_d    = md_cnt_q;
      pend_addr_d = pend_addr_q;
      stall_cnt_d = stall_cnt_q;
      unique case (state_q)
         StRun: begin
            if (jump_en_i) begin
               if (bus_wait_i) begin
                  pend_addr_d = jump_addr_i;
                  state_d     = StJmpPend;
               end
            end else if (md_start_i) begin
               md_cnt_d = '0;
               state_d  = StMdWait;
            end
         end
         StMdWait: begin
            if (md_done_i || (md_cnt_q == MdLast)) begin
               state_d = StRun;
            end else begin
               md_cnt_d = md_cnt_q + CW'(1);
            end
         end
         StJmpPend: begin
            if (!bus_wait_i) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
      if (hold_pc_o && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_comb begin
      hold_pc_o       = 1'b0;
      hold_if_id_o    = 1'b0;
      hold_id_ex_o    = 1'b0;
      bubble_id_ex_o  = 1'b0;
      bubble_ex_mem_o = 1'b0;
      flush_o         = 1'b0;
      jump_en_o       = 1'b0;
      jump_addr_o     = '0;
      md_timeout_o    = 1'b0;
      stall_cnt_o     = '0;
      if (rst) begin
         stall_cnt_o = stall_cnt_q;
         unique case (state_q)
            StRun: begin
               if (jump_en_i) begin
                  if (!bus_wait_i) begin
                     jump_en_o   = 1'b1;
                     jump_addr_o = jump_addr_i;
                     flush_o     = 1'b1;
                  end else begin
                     hold_pc_o    = 1'b1;
                     hold_if_id_o = 1'b1;
                     hold_id_ex_o = 1'b1;
                  end
               end else if (md_start_i) begin
                  // Issue cycle proceeds normally; holds begin next cycle.
               end else if (bus_wait_i) begin
                  hold_pc_o    = 1'b1;
                  hold_if_id_o = 1'b1;
                  hold_id_ex_o = 1'b1;
               end else if (load_use) begin
                  hold_pc_o      = 1'b1;
                  hold_if_id_o   = 1'b1;
                  bubble_id_ex_o = 1'b1;
               end
            end
            StMdWait: begin
               if (!md_done_i) begin
                  hold_pc_o       = 1'b1;
                  hold_if_id_o    = 1'b1;
                  hold_id_ex_o    = 1'b1;
                  bubble_ex_mem_o = 1'b1;
                  md_timeout_o    = (md_cnt_q == MdLast);
               end
            end
            StJmpPend: begin
               if (bus_wait_i) begin
                  hold_pc_o    = 1'b1;
                  hold_if_id_o = 1'b1;
                  hold_id_ex_o = 1'b1;
               end else begin
                  jump_en_o   = 1'b1;
                  jump_addr_o = pend_addr_q;
                  flush_o     = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run against a
// cycle-level behavioural model (countdown for mul/div, queue for the parked jump).
module tb_pipe_ctrl;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        ex_load_i;
   logic [4:0]  ex_rd_i, id_rs1_i, id_rs2_i;
   logic        id_rs1_en_i, id_rs2_en_i;
   logic        md_start_i, md_done_i, bus_wait_i;
   logic        hold_pc_o, hold_if_id_o, hold_id_ex_o, bubble_id_ex_o, bubble_ex_mem_o;
   logic        flush_o, jump_en_o, md_timeout_o;
   logic [31:0] jump_addr_o;
   logic [15:0] stall_cnt_o;
   logic [7:0]  ctl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.AW(32), .MD_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_en_i(id_rs1_en_i), .id_rs2_en_i(id_rs2_en_i),
      .md_start_i(md_start_i), .md_done_i(md_done_i), .bus_wait_i(bus_wait_i),
      .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
      .bubble_id_ex_o(bubble_id_ex_o), .bubble_ex_mem_o(bubble_ex_mem_o),
      .flush_o(flush_o), .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
      .md_timeout_o(md_timeout_o), .stall_cnt_o(stall_cnt_o)
   );

   // {hold_pc, hold_if_id, hold_id_ex, bubble_id_ex, bubble_ex_mem, flush, jump_en, md_timeout}
   assign ctl = {hold_pc_o, hold_if_id_o, hold_id_ex_o, bubble_id_ex_o, bubble_ex_mem_o,
                 flush_o, jump_en_o, md_timeout_o};

   task automatic set_idle();
      rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; ex_load_i = 1'b0; ex_rd_i = '0;
      id_rs1_i = '0; id_rs2_i = '0; id_rs1_en_i = 1'b0; id_rs2_en_i = 1'b0;
      md_start_i = 1'b0; md_done_i = 1'b0; bus_wait_i = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      set_idle(); rst = 1'b0; tick(); rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; jump_en_i = 1'b1; jump_addr_i = '1; ex_load_i = 1'b1; ex_rd_i = '1;
      id_rs1_i = '1; id_rs2_i = '1; id_rs1_en_i = 1'b1; id_rs2_en_i = 1'b1;
      md_start_i = 1'b1; md_done_i = 1'b1; bus_wait_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({ctl, jump_addr_o, stall_cnt_o} !== 56'd0) begin
            errors++;
            $display("FAIL reset_outs cyc %0d got ctl=%b addr=%h cnt=%0d want all 0",
                     i, ctl, jump_addr_o, stall_cnt_o);
         end
         tick();
      end
      set_idle(); #1;
      checks++;
      if ({ctl, jump_addr_o, stall_cnt_o} !== 56'd0) begin
         errors++;
         $display("FAIL post_reset got ctl=%b addr=%h cnt=%0d want all 0",
                  ctl, jump_addr_o, stall_cnt_o);
      end
      tick();
      // Only RUN redirects straight to jump_addr_i.
      jump_en_i = 1'b1; jump_addr_i = 32'h10; #1;
      checks++;
      if (ctl !== 8'b0000_0110 || jump_addr_o !== 32'h10) begin
         errors++;
         $display("FAIL reset_is_run got ctl=%b addr=%h want 00000110 addr 10", ctl, jump_addr_o);
      end
      tick(); set_idle();
   endtask

   task automatic test_load_use();
      pulse_reset();
      ex_load_i = 1'b1; ex_rd_i = 5'd5; id_rs2_en_i = 1'b1; id_rs2_i = 5'd5; #1;
      checks++;
      if (ctl !== 8'b1101_0000) begin
         errors++; $display("FAIL load_use got %b want 11010000", ctl);
      end
      tick(); set_idle(); #1;
      checks++;
      if (ctl !== 8'b0) begin
         errors++; $display("FAIL load_use_clear got %b want 00000000", ctl);
      end
      tick();
      ex_load_i = 1'b1; ex_rd_i = 5'd0; id_rs2_en_i = 1'b1; id_rs2_i = 5'd0; #1;
      checks++;
      if (ctl !== 8'b0) begin
         errors++; $display("FAIL load_use_x0 got %b want 00000000", ctl);
      end
      tick();
      ex_rd_i = 5'd7; id_rs2_en_i = 1'b0; id_rs1_en_i = 1'b0; id_rs1_i = 5'd7; #1;
      checks++;
      if (ctl !== 8'b0) begin
         errors++; $display("FAIL load_use_noen got %b want 00000000", ctl);
      end
      tick();
      id_rs1_en_i = 1'b1; #1;
      checks++;
      if (ctl !== 8'b1101_0000) begin
         errors++; $display("FAIL load_use_rs1 got %b want 11010000", ctl);
      end
      tick(); set_idle(); #1;
      checks++;
      if (stall_cnt_o !== 16'd2) begin
         errors++; $display("FAIL load_use_cnt got %0d want 2", stall_cnt_o);
      end
      tick();
   endtask

   task automatic test_md_done();
      pulse_reset();
      md_start_i = 1'b1; #1;
      checks++;
      if (ctl !== 8'b0) begin
         errors++; $display("FAIL md_start_cycle got %b want 00000000", ctl);
      end
      tick(); md_start_i = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         md_done_i = (i == 4); #1;
         checks++;
         if (ctl !== ((i == 4) ? 8'b0 : 8'b1110_1000)) begin
            errors++; $display("FAIL md_wait cyc %0d got %b", i, ctl);
         end
         tick();
      end
      set_idle(); #1;
      checks++;
      if (ctl !== 8'b0 || stall_cnt_o !== 16'd3) begin
         errors++; $display("FAIL md_done_after got ctl=%b cnt=%0d want 0 cnt 3", ctl, stall_cnt_o);
      end
      tick();
   endtask

   task automatic test_md_timeout();
      pulse_reset();
      md_start_i = 1'b1; tick(); md_start_i = 1'b0;
      for (int i = 0; i < int'(TO); i++) begin
         #1;
         checks++;
         if (ctl !== ((i == int'(TO) - 1) ? 8'b1110_1001 : 8'b1110_1000)) begin
            errors++; $display("FAIL md_timeout cyc %0d got %b", i, ctl);
         end
         tick();
      end
      #1;
      checks++;
      if (ctl !== 8'b0 || stall_cnt_o !== 16'(TO)) begin
         errors++;
         $display("FAIL md_timeout_after got ctl=%b cnt=%0d want 0 cnt %0d", ctl, stall_cnt_o, TO);
      end
      tick();
   endtask

   task automatic test_jump_idle();
      pulse_reset();
      jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100; md_start_i = 1'b1;
      ex_load_i = 1'b1; ex_rd_i = 5'd3; id_rs1_en_i = 1'b1; id_rs1_i = 5'd3; #1;
      checks++;
      if (ctl !== 8'b0000_0110 || jump_addr_o !== 32'h100) begin
         errors++; $display("FAIL jump_idle got ctl=%b addr=%h want 00000110 100", ctl, jump_addr_o);
      end
      tick(); set_idle(); #1;
      checks++;
      if (ctl !== 8'b0 || jump_addr_o !== 32'h0) begin
         errors++; $display("FAIL jump_idle_after got ctl=%b addr=%h want 0", ctl, jump_addr_o);
      end
      tick();
   endtask

   task automatic test_deferred_jump();
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         bus_wait_i = 1'b1;
         jump_en_i = (i != 2);
         jump_addr_i = (i == 0) ? 32'h200 : 32'h300;
         #1;
         checks++;
         if (ctl !== 8'b1110_0000 || jump_addr_o !== 32'h0) begin
            errors++; $display("FAIL defer_hold cyc %0d got ctl=%b addr=%h", i, ctl, jump_addr_o);
         end
         tick();
      end
      set_idle(); #1;
      checks++;
      if (ctl !== 8'b0000_0110 || jump_addr_o !== 32'h200) begin
         errors++; $display("FAIL defer_redirect got ctl=%b addr=%h want 00000110 200",
                            ctl, jump_addr_o);
      end
      tick(); #1;
      checks++;
      if (ctl !== 8'b0 || stall_cnt_o !== 16'd3) begin
         errors++; $display("FAIL defer_single got ctl=%b cnt=%0d want 0 cnt 3", ctl, stall_cnt_o);
      end
      tick();
   endtask

   task automatic test_reset_in_pend();
      pulse_reset();
      jump_en_i = 1'b1; jump_addr_i = 32'h400; bus_wait_i = 1'b1; tick();
      set_idle(); rst = 1'b0; #1;
      checks++;
      if ({ctl, jump_addr_o} !== 40'd0) begin
         errors++; $display("FAIL pend_reset got ctl=%b addr=%h want 0", ctl, jump_addr_o);
      end
      tick(); rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if ({ctl, jump_addr_o} !== 40'd0) begin
            errors++; $display("FAIL pend_discard cyc %0d got ctl=%b addr=%h want 0",
                               i, ctl, jump_addr_o);
         end
         tick();
      end
   endtask

   task automatic test_random();
      int          md_left;
      int          stall_m;
      logic [31:0] pend_q[$];
      logic [7:0]  e_ctl;
      logic [31:0] e_addr;
      logic [15:0] e_stall;
      logic        lu;
      pulse_reset();
      md_left = 0; stall_m = 0; pend_q.delete();
      for (int n = 0; n < 2000; n++) begin
         rst         = ($urandom_range(0, 79) != 0);
         jump_en_i   = ($urandom_range(0, 4) == 0);
         jump_addr_i = $urandom;
         ex_load_i   = $urandom_range(0, 1) == 1;
         ex_rd_i     = 5'($urandom_range(0, 3));
         id_rs1_i    = 5'($urandom_range(0, 3));
         id_rs2_i    = 5'($urandom_range(0, 3));
         id_rs1_en_i = $urandom_range(0, 1) == 1;
         id_rs2_en_i = $urandom_range(0, 1) == 1;
         md_start_i  = ($urandom_range(0, 11) == 0);
         md_done_i   = ($urandom_range(0, 5) == 0);
         bus_wait_i  = ($urandom_range(0, 2) == 0);
         #1;
         e_ctl = '0; e_addr = '0; e_stall = '0;
         if (!rst) begin
            md_left = 0; stall_m = 0; pend_q.delete();
         end else begin
            e_stall = 16'(stall_m);
            lu = ex_load_i && ex_rd_i != 0 &&
                 ((id_rs1_en_i && id_rs1_i == ex_rd_i) || (id_rs2_en_i && id_rs2_i == ex_rd_i));
            if (md_left > 0) begin
               if (md_done_i) md_left = 0;
               else begin
                  e_ctl = 8'b1110_1000;
                  if (md_left == 1) e_ctl[0] = 1'b1;
                  md_left--;
               end
            end else if (pend_q.size() > 0) begin
               if (bus_wait_i) e_ctl = 8'b1110_0000;
               else begin e_ctl = 8'b0000_0110; e_addr = pend_q.pop_front(); end
            end else if (jump_en_i) begin
               if (!bus_wait_i) begin e_ctl = 8'b0000_0110; e_addr = jump_addr_i; end
               else begin e_ctl = 8'b1110_0000; pend_q.push_back(jump_addr_i); end
            end else if (md_start_i) md_left = TO;
            else if (bus_wait_i) e_ctl = 8'b1110_0000;
            else if (lu) e_ctl = 8'b1101_0000;
            if (e_ctl[7] && stall_m < 65535) stall_m++;
         end
         checks++;
         if (ctl !== e_ctl || jump_addr_o !== e_addr || stall_cnt_o !== e_stall) begin
            errors++;
            $display("FAIL random cyc %0d got ctl=%b addr=%h cnt=%0d want ctl=%b addr=%h cnt=%0d",
                     n, ctl, jump_addr_o, stall_cnt_o, e_ctl, e_addr, e_stall);
         end
         tick();
      end
      set_idle();
   endtask

   initial begin
      set_idle(); rst = 1'b0;
      tick();
      test_reset();
      test_load_use();
      test_md_done();
      test_md_timeout();
      test_jump_idle();
      test_deferred_jump();
      test_reset_in_pend();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
